// File: rtl/busy_table_pkg.sv
// Shared definitions for the physical-register busy table: default register-file depth
// and the physical-register address type.
package busy_table_pkg;
  localparam int PHY_RF_DEPTH_DEF = 128;
  typedef logic [$clog2(PHY_RF_DEPTH_DEF)-1:0] phyreg_addr_t;
endpackage

// File: rtl/busy_table_popcount.sv
// Combinational population count of a WIDTH-bit vector.
module busy_table_popcount #(
  parameter int WIDTH = 128
) (
  input  logic [WIDTH-1:0]       i_vec,
  output logic [$clog2(WIDTH):0] o_count
);

  always_comb begin
    o_count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      o_count = o_count + {{$clog2(WIDTH){1'b0}}, i_vec[i]};
    end
  end

endmodule

// File: rtl/busy_table.sv
// Physical-register busy table: map sets, writeback clears, flush wipes, issue reads.
// Optional same-cycle writeback bypass on reads when QU_BUSY_TABLE_BYPASS_EN is defined.
module busy_table
  import busy_table_pkg::*;
#(
  parameter int PHY_RF_DEPTH = PHY_RF_DEPTH_DEF,
  parameter int NUM_WB_PORTS = 2,
  parameter int NUM_RD_PORTS = 4,
  localparam int AW = $clog2(PHY_RF_DEPTH)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic                             busy_wr_en,
  input  logic [AW-1:0]                    busy_wr_addr,
  input  logic                             busy_data_in,
  input  logic [NUM_WB_PORTS-1:0]          wb_valid,
  input  logic [NUM_WB_PORTS-1:0][AW-1:0]  wb_addr,
  input  logic                             flush,
  input  logic [NUM_RD_PORTS-1:0][AW-1:0]  rd_addr,
  output logic [NUM_RD_PORTS-1:0]          rd_busy,
  output logic [AW:0]                      busy_count,
  output logic                             err_clr_free
);

  logic [PHY_RF_DEPTH-1:0] r_busy;
  logic [AW:0]             r_count;
  logic                    r_err;

  logic [PHY_RF_DEPTH-1:0] w_busy_nxt;
  logic [AW:0]             w_count_nxt;
  logic                    w_err_hit;
  logic                    w_map_we;
  logic                    w_map_set;
  logic [NUM_RD_PORTS-1:0] w_rd_busy;

  assign w_map_we  = en && busy_wr_en && (busy_wr_addr != '0);
  assign w_map_set = w_map_we && busy_data_in;

  // Clears first, then the map write so a same-cycle set wins; flush overrides everything.
  always_comb begin
    w_busy_nxt = r_busy;
    w_err_hit  = 1'b0;
    for (int i = 0; i < NUM_WB_PORTS; i++) begin
      if (wb_valid[i] && (wb_addr[i] != '0)) begin
        if (!r_busy[wb_addr[i]] && !(w_map_set && (busy_wr_addr == wb_addr[i]))) begin
          w_err_hit = 1'b1;
        end
        w_busy_nxt[wb_addr[i]] = 1'b0;
      end
    end
    if (w_map_we) begin
      w_busy_nxt[busy_wr_addr] = busy_data_in;
    end
    if (flush) begin
      w_busy_nxt = '0;
    end
  end

  busy_table_popcount #(
    .WIDTH (PHY_RF_DEPTH)
  ) u_popcount (
    .i_vec   (w_busy_nxt),
    .o_count (w_count_nxt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy  <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      r_busy  <= w_busy_nxt;
      r_count <= w_count_nxt;
      if (!flush && w_err_hit) begin
        r_err <= 1'b1;
      end
    end
  end

  always_comb begin
    w_rd_busy = '0;
    for (int j = 0; j < NUM_RD_PORTS; j++) begin
      w_rd_busy[j] = (rd_addr[j] != '0) && r_busy[rd_addr[j]];
`ifdef QU_BUSY_TABLE_BYPASS_EN
      // A completing result wakes its consumers this cycle unless map re-allocates it now.
      for (int i = 0; i < NUM_WB_PORTS; i++) begin
        if (wb_valid[i] && (wb_addr[i] == rd_addr[j]) &&
            !(w_map_set && (busy_wr_addr == rd_addr[j]))) begin
          w_rd_busy[j] = 1'b0;
        end
      end
`endif
    end
  end

  assign rd_busy      = w_rd_busy;
  assign busy_count   = r_count;
  assign err_clr_free = r_err;

endmodule
